// File: rtl/mem_copy_dma_if.sv
// Control and data-memory signal bundle for the block-copy engine.
// The master side is the copy engine; the slave side is the controller plus memory.
interface mem_copy_dma_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          start;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;
    logic [AW-1:0] len;
    logic          busy;
    logic          done;
    logic [DW-1:0] checksum;
    logic          mem_wen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport master (
        input  start, src_addr, dst_addr, len, mem_rdata,
        output busy, done, checksum, mem_wen, mem_addr, mem_wdata
    );

    modport slave (
        output start, src_addr, dst_addr, len, mem_rdata,
        input  busy, done, checksum, mem_wen, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_copy_dma.sv
// Forward block copy through a registered-address data memory, two cycles per
// word, with a running modular checksum of the words moved.
module mem_copy_dma #(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_copy_dma_if.master        bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [AW-1:0] len_q, len_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [DW-1:0] checksum_q, checksum_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            checksum_q <= '0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            checksum_q <= checksum_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        len_d      = len_q;
        idx_d      = idx_q;
        checksum_d = checksum_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    src_d      = bus.src_addr;
                    dst_d      = bus.dst_addr;
                    len_d      = bus.len;
                    idx_d      = '0;
                    checksum_d = '0;
                    state_d    = (bus.len == '0) ? DONE : READ;
                end
            end
            READ: state_d = WRITE;
            WRITE: begin
                // mem_rdata here is the source word latched at the READ->WRITE edge
                checksum_d = checksum_q + bus.mem_rdata;
                if (idx_q == len_q - AW'(1)) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + AW'(1);
                    state_d = READ;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.mem_wen   = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        case (state_q)
            READ: bus.mem_addr = src_q + idx_q;
            WRITE: begin
                bus.mem_addr  = dst_q + idx_q;
                bus.mem_wen   = 1'b1;
                bus.mem_wdata = bus.mem_rdata;
            end
            default: ;
        endcase
    end

    assign bus.busy     = (state_q == READ) || (state_q == WRITE);
    assign bus.done     = (state_q == DONE);
    assign bus.checksum = checksum_q;
endmodule

// File: tb/tb_mem_copy_dma.sv
// Directed-vector bench for mem_copy_dma with a registered-address memory model.
module tb_mem_copy_dma;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_copy_dma_if #(.AW(16), .DW(16)) bus ();

    mem_copy_dma #(.AW(16), .DW(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [15:0] mem [0:65535];
    logic [15:0] rd_addr_q;
    logic        pre_we = 1'b0;
    logic [15:0] pre_addr = '0;
    logic [15:0] pre_data = '0;

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (bus.mem_wen) mem[bus.mem_addr] <= bus.mem_wdata;
        rd_addr_q <= bus.mem_addr;
    end
    assign bus.mem_rdata = mem[rd_addr_q];

    int vectors = 0;
    int errors  = 0;

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        @(posedge clk); #1;
        pre_we   = 1'b0;
    endtask

    // Starts a copy from an IDLE cycle and measures it; returns in the IDLE cycle after done.
    task automatic run_copy(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] n,
                            output int done_cyc, output int busy_cnt, output int wen_cnt,
                            output logic [15:0] cks, output logic [15:0] addr_c1,
                            output logic [15:0] addr_c2, output logic [15:0] wdata_c2);
        done_cyc = -1; busy_cnt = 0; wen_cnt = 0; cks = 'x;
        addr_c1 = 'x; addr_c2 = 'x; wdata_c2 = 'x;
        bus.src_addr = src; bus.dst_addr = dst; bus.len = n; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int c = 1; c <= 2 * int'(n) + 10; c++) begin
            if (c == 1) addr_c1 = bus.mem_addr;
            if (c == 2) begin addr_c2 = bus.mem_addr; wdata_c2 = bus.mem_wdata; end
            if (bus.busy) busy_cnt++;
            if (bus.mem_wen) wen_cnt++;
            if (bus.done) begin
                done_cyc = c;
                cks = bus.checksum;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", bus.busy); end
        vectors++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", bus.done); end
        vectors++; if (bus.checksum !== 16'h0) begin errors++; $display("FAIL reset_checksum got %h want 0000", bus.checksum); end
        vectors++; if (bus.mem_wen !== 1'b0) begin errors++; $display("FAIL reset_wen got %0b want 0", bus.mem_wen); end
        vectors++; if (bus.mem_addr !== 16'h0) begin errors++; $display("FAIL reset_addr got %h want 0000", bus.mem_addr); end
        vectors++; if (bus.mem_wdata !== 16'h0) begin errors++; $display("FAIL reset_wdata got %h want 0000", bus.mem_wdata); end
        $display("test_reset: outputs checked after reset");
    endtask

    task automatic test_basic_copy;
        int dc, bc, wc;
        logic [15:0] ck, a1, a2, w2;
        logic [15:0] exp_w [4];
        exp_w[0] = 16'h1111; exp_w[1] = 16'h2222; exp_w[2] = 16'h3333; exp_w[3] = 16'h4444;
        for (int i = 0; i < 4; i++) preload(16'h0010 + 16'(i), exp_w[i]);
        run_copy(16'h0010, 16'h0040, 16'd4, dc, bc, wc, ck, a1, a2, w2);
        vectors++; if (dc !== 9) begin errors++; $display("FAIL basic_done_cycle got %0d want 9", dc); end
        vectors++; if (bc !== 8) begin errors++; $display("FAIL basic_busy_cycles got %0d want 8", bc); end
        vectors++; if (wc !== 4) begin errors++; $display("FAIL basic_writes got %0d want 4", wc); end
        vectors++; if (ck !== 16'hAAAA) begin errors++; $display("FAIL basic_checksum got %h want aaaa", ck); end
        vectors++; if (a1 !== 16'h0010) begin errors++; $display("FAIL basic_read_addr got %h want 0010", a1); end
        vectors++; if (a2 !== 16'h0040) begin errors++; $display("FAIL basic_write_addr got %h want 0040", a2); end
        vectors++; if (w2 !== 16'h1111) begin errors++; $display("FAIL basic_wdata got %h want 1111", w2); end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (mem[16'h0040 + 16'(i)] !== exp_w[i]) begin
                errors++; $display("FAIL basic_dst[%0d] got %h want %h", i, mem[16'h0040 + 16'(i)], exp_w[i]);
            end
        end
        vectors++; if (bus.checksum !== 16'hAAAA) begin errors++; $display("FAIL basic_checksum_held got %h want aaaa", bus.checksum); end
        $display("test_basic_copy: done_cycle=%0d busy=%0d writes=%0d checksum=%h", dc, bc, wc, ck);
    endtask

    task automatic test_zero_len;
        int dc, bc, wc;
        logic [15:0] ck, a1, a2, w2;
        run_copy(16'h0010, 16'h0080, 16'd0, dc, bc, wc, ck, a1, a2, w2);
        vectors++; if (dc !== 1) begin errors++; $display("FAIL zero_done_cycle got %0d want 1", dc); end
        vectors++; if (wc !== 0) begin errors++; $display("FAIL zero_writes got %0d want 0", wc); end
        vectors++; if (bc !== 0) begin errors++; $display("FAIL zero_busy got %0d want 0", bc); end
        vectors++; if (ck !== 16'h0) begin errors++; $display("FAIL zero_checksum got %h want 0000", ck); end
        $display("test_zero_len: done_cycle=%0d writes=%0d checksum=%h", dc, wc, ck);
    endtask

    task automatic test_wrap;
        int dc, bc, wc;
        logic [15:0] ck, a1, a2, w2;
        preload(16'hFFFE, 16'h00AA);
        preload(16'hFFFF, 16'h00BB);
        preload(16'h0000, 16'h00CC);
        run_copy(16'hFFFE, 16'h0100, 16'd3, dc, bc, wc, ck, a1, a2, w2);
        vectors++; if (mem[16'h0100] !== 16'h00AA) begin errors++; $display("FAIL wrap_dst0 got %h want 00aa", mem[16'h0100]); end
        vectors++; if (mem[16'h0101] !== 16'h00BB) begin errors++; $display("FAIL wrap_dst1 got %h want 00bb", mem[16'h0101]); end
        vectors++; if (mem[16'h0102] !== 16'h00CC) begin errors++; $display("FAIL wrap_dst2 got %h want 00cc", mem[16'h0102]); end
        vectors++; if (ck !== 16'h0231) begin errors++; $display("FAIL wrap_checksum got %h want 0231", ck); end
        vectors++; if (dc !== 7) begin errors++; $display("FAIL wrap_done_cycle got %0d want 7", dc); end
        $display("test_wrap: done_cycle=%0d checksum=%h", dc, ck);
    endtask

    task automatic test_checksum_overflow;
        int dc, bc, wc;
        logic [15:0] ck, a1, a2, w2;
        preload(16'h0200, 16'hFFFF);
        preload(16'h0201, 16'h0003);
        run_copy(16'h0200, 16'h0300, 16'd2, dc, bc, wc, ck, a1, a2, w2);
        vectors++; if (ck !== 16'h0002) begin errors++; $display("FAIL ovf_checksum got %h want 0002", ck); end
        vectors++; if (dc !== 5) begin errors++; $display("FAIL ovf_done_cycle got %0d want 5", dc); end
        $display("test_checksum_overflow: checksum=%h", ck);
    endtask

    task automatic test_back_to_back;
        int dc, bc, wc, first_done;
        logic [15:0] ck, a1, a2, w2;
        preload(16'h0060, 16'hDEAD);
        preload(16'h0061, 16'hBEEF);
        first_done = -1;
        bus.src_addr = 16'h0010; bus.dst_addr = 16'h0050; bus.len = 16'd4; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (c == 3) begin
                bus.src_addr = 16'h0200; bus.dst_addr = 16'h0060; bus.len = 16'd2; bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done) begin
                first_done = c;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        vectors++; if (first_done !== 9) begin errors++; $display("FAIL b2b_first_done got %0d want 9", first_done); end
        vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy got %0b want 0", bus.busy); end
        run_copy(16'h0200, 16'h0070, 16'd2, dc, bc, wc, ck, a1, a2, w2);
        vectors++; if (dc !== 5) begin errors++; $display("FAIL b2b_second_done got %0d want 5", dc); end
        vectors++; if (ck !== 16'h0002) begin errors++; $display("FAIL b2b_checksum got %h want 0002", ck); end
        vectors++; if (mem[16'h0053] !== 16'h4444) begin errors++; $display("FAIL b2b_first_dst got %h want 4444", mem[16'h0053]); end
        vectors++; if (mem[16'h0060] !== 16'hDEAD) begin errors++; $display("FAIL b2b_ignored0 got %h want dead", mem[16'h0060]); end
        vectors++; if (mem[16'h0061] !== 16'hBEEF) begin errors++; $display("FAIL b2b_ignored1 got %h want beef", mem[16'h0061]); end
        vectors++; if (mem[16'h0070] !== 16'hFFFF) begin errors++; $display("FAIL b2b_second_dst0 got %h want ffff", mem[16'h0070]); end
        vectors++; if (mem[16'h0071] !== 16'h0003) begin errors++; $display("FAIL b2b_second_dst1 got %h want 0003", mem[16'h0071]); end
        $display("test_back_to_back: first_done=%0d second_done=%0d", first_done, dc);
    endtask

    task automatic test_reset_mid_copy;
        int done_seen, wen_seen;
        for (int i = 0; i < 4; i++) begin
            preload(16'h0020 + 16'(i), 16'h0A01 + 16'(i));
            preload(16'h0040 + 16'(i), 16'h0000);
        end
        bus.src_addr = 16'h0020; bus.dst_addr = 16'h0040; bus.len = 16'd4; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        // cycle 4: WRITE of word 1
        vectors++; if (bus.mem_addr !== 16'h0041) begin errors++; $display("FAIL rstmid_write1_addr got %h want 0041", bus.mem_addr); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %0b want 0", bus.busy); end
        vectors++; if (bus.checksum !== 16'h0) begin errors++; $display("FAIL rstmid_checksum got %h want 0000", bus.checksum); end
        done_seen = 0; wen_seen = 0;
        for (int c = 0; c < 12; c++) begin
            if (bus.done) done_seen++;
            if (bus.mem_wen) wen_seen++;
            @(posedge clk); #1;
        end
        vectors++; if (done_seen !== 0) begin errors++; $display("FAIL rstmid_done got %0d want 0", done_seen); end
        vectors++; if (wen_seen !== 0) begin errors++; $display("FAIL rstmid_wen got %0d want 0", wen_seen); end
        vectors++; if (mem[16'h0040] !== 16'h0A01) begin errors++; $display("FAIL rstmid_dst0 got %h want 0a01", mem[16'h0040]); end
        vectors++; if (mem[16'h0042] !== 16'h0000) begin errors++; $display("FAIL rstmid_dst2 got %h want 0000", mem[16'h0042]); end
        vectors++; if (mem[16'h0043] !== 16'h0000) begin errors++; $display("FAIL rstmid_dst3 got %h want 0000", mem[16'h0043]); end
        $display("test_reset_mid_copy: done_pulses=%0d writes_after_reset=%0d", done_seen, wen_seen);
    endtask

    initial begin
        bus.start = 1'b0; bus.src_addr = '0; bus.dst_addr = '0; bus.len = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset;
        rst = 1'b0;
        @(posedge clk); #1;
        test_basic_copy;
        test_zero_len;
        test_wrap;
        test_checksum_overflow;
        test_back_to_back;
        test_reset_mid_copy;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/mem_copy_dma.md
# mem_copy_dma

Block-copy engine that acts as the initiator on the data-memory port. Given source address, destination address and word count, it reads each word through the memory's registered-address read path and writes it back at the destination. It also accumulates a modular checksum of the copied words. It sits between the testbench/control logic and the data memory, driving the memory's `wen`, `addr` and `data_in` and consuming its `data_out`.

## Interface
Parameters:
- AW, 16: address width; matches the data memory address width.
- DW, 16: data width; matches the data memory data width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  request a copy; sampled only in IDLE.
- src_addr  in  AW  first source word address; captured on accepted start.
- dst_addr  in  AW  first destination word address; captured on accepted start.
- len  in  AW  number of words to copy; captured on accepted start.
- busy  out  1  high in READ and WRITE states.
- done  out  1  one-cycle pulse when a copy completes.
- checksum  out  DW  sum mod 2^DW of all words copied; valid while done=1, held until the next accepted start.
- mem_wen  out  1  memory write enable, active-high.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data; reflects the address presented one cycle earlier.

## Operation
- States:
  - IDLE: no memory activity.
  - READ: issue the read of word i.
  - WRITE: write word i.
  - DONE: completion pulse.
- Internal registers:
  - src_r, dst_r, len_r: AW bits, captured on start.
  - idx: AW-bit word index.
  - checksum: DW bits.
- Transitions:
  - IDLE, start=1, len≠0: capture src/dst/len, clear idx and checksum, go to READ.
  - IDLE, start=1, len=0: capture, clear checksum, go to DONE. No memory access is issued.
  - READ: go to WRITE unconditionally.
  - WRITE: go to DONE if idx==len_r-1. Otherwise increment idx and go to READ.
  - DONE: go to IDLE.
- Memory drive (combinational from state and registers):
  - READ: mem_addr=src_r+idx, mem_wen=0, mem_wdata=0.
  - WRITE: mem_addr=dst_r+idx, mem_wen=1, mem_wdata=mem_rdata.
  - IDLE/DONE: mem_addr=0, mem_wen=0, mem_wdata=0.
- Checksum: on each WRITE edge, checksum ← checksum + mem_rdata, truncated to DW bits.
- Address arithmetic is mod 2^AW. src_r+idx and dst_r+idx wrap past 2^AW-1 to 0.
- start is ignored in READ, WRITE and DONE. No queuing.
- Overlap semantics are forward copy, ascending addresses:
  - dst ≤ src, or non-overlapping ranges: exact copy.
  - src < dst < src+len: source words already overwritten are re-read. This result is defined behaviour, not an error.

## Timing
- Reset values: state=IDLE, busy=0, done=0, checksum=0, mem_wen=0, mem_addr=0, mem_wdata=0, idx=0.
- Reset mid-copy: at the rst edge the state returns to IDLE. mem_wen is 0 from the next cycle, and no further writes occur. No done pulse is produced for the aborted copy.
- start must not be asserted while rst=1. The memory performs its file load under reset, and the block ignores start during reset.
- Throughput: 2 cycles per word.
- Latency, start accepted at edge E0 with len=N≥1:
  - READ word i in cycle 2i+1 after E0.
  - WRITE word i in cycle 2i+2 after E0.
  - done=1 in cycle 2N+1.
  - Back in IDLE in cycle 2N+2; a new start is accepted at that cycle's edge.
- len=0: done=1 in cycle 1 after E0, checksum=0.
- Read latency reliance: the address presented in READ is registered by the memory at the READ→WRITE edge, so mem_rdata during WRITE is the source word. mem_wdata is a combinational pass-through.
- Maximum len (2^AW-1) completes in 2·len+1 cycles. idx never wraps.

## Test plan
- Basic copy:
  - Stimulus: preload mem[0x10..0x13]=0x1111,0x2222,0x3333,0x4444; start src=0x10, dst=0x40, len=4.
  - Required: mem[0x40..0x43] match the source, busy for 8 cycles, done pulse in cycle 9, checksum=0xAAAA.
- Zero length:
  - Stimulus: start with len=0.
  - Required: no mem_wen assertion, done in cycle 1, checksum=0.
- Wrap-around:
  - Stimulus: src=0xFFFE, dst=0x0100, len=3, mem[0xFFFE]=0x00AA, mem[0xFFFF]=0x00BB, mem[0x0000]=0x00CC.
  - Required: mem[0x100..0x102]=0x00AA,0x00BB,0x00CC.
- Checksum overflow:
  - Stimulus: copy 2 words 0xFFFF,0x0003.
  - Required: checksum=0x0002.
- Start while busy, then back-to-back:
  - Stimulus: assert start in cycle 3 of a len=4 copy.
  - Required: it is ignored and the destination is unchanged beyond the first copy.
  - Stimulus: start in the first IDLE cycle after done.
  - Required: the second copy runs normally.
- Reset mid-copy:
  - Stimulus: assert rst during the WRITE of word 1 of a len=4 copy to dst=0x40.
  - Required: mem[0x40] written, no writes after reset, busy=0, done never pulses, checksum=0.
